wb_write_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback, which has default priority;
  - the multi-cycle multiply/divide unit (MDU), whose results are buffered here.
- Sits between the WB stage / MDU and the register-write bundle sent to DE.
- Owns port arbitration, MDU result buffering, starvation control and x0 write suppression.

---
 rtl/wb_write_arbiter_pkg.sv | 22 ++
 rtl/wb_write_arbiter_mdu_fifo.sv | 60 ++++++
 rtl/wb_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the arbiter state encoding and the write-bundle width helper used
// to pack {wr_reg, wregno, regval} for the from_WB_to_DE path.
package wb_write_arbiter_pkg;

    // S_PIPE: pipeline has priority; S_DRAIN: buffered MDU head is forced through.
    typedef enum logic {
        S_PIPE  = 1'b0,
        S_DRAIN = 1'b1
    } arb_state_t;

    localparam int DEF_DBITS     = 32;
    localparam int DEF_REGNOBITS = 5;

    // Width of the packed write bundle {wr_reg, wregno, regval}.
    function automatic int wb_bundle_w(input int regnobits, input int dbits);
        return regnobits + dbits + 1;
    endfunction

    localparam int DEF_BUNDLE_W = DEF_REGNOBITS + DEF_DBITS + 1;

endpackage

// File: rtl/wb_write_arbiter_mdu_fifo.sv
// wb_mdu_fifo: small synchronous FIFO buffering MDU results.
// DEPTH must be a power of 2 so the pointers wrap by plain overflow.
// Full/empty come from registered occupancy only.
module wb_mdu_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage write; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between the
// in-order pipeline writeback (default priority) and buffered MDU results.
// A buffered MDU result that loses STARVE_LIMIT consecutive cycles is
// forced through in S_DRAIN, stalling the pipeline for that cycle.
// Writes to x0 are suppressed. Optional macro WB_ARB_PERF_EN adds
// free-running grant/stall counters.
//
// MDU handshake: a result transfers on a rising edge where mdu_valid and
// mdu_ready are both high; mdu_ready depends only on registered occupancy
// and reset, never on mdu_valid, and the MDU holds its result until taken.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DBITS          = 32,
    parameter int REGNOBITS      = 5,
    parameter int MDU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_wr_valid,
    input  logic [REGNOBITS-1:0] pipe_wregno,
    input  logic [DBITS-1:0]     pipe_regval,
    output logic                 pipe_stall,
    input  logic                 mdu_valid,
    output logic                 mdu_ready,
    input  logic [REGNOBITS-1:0] mdu_wregno,
    input  logic [DBITS-1:0]     mdu_regval,
    output logic                 wr_reg_out,
    output logic [REGNOBITS-1:0] wregno_out,
    output logic [DBITS-1:0]     regval_out,
`ifdef WB_ARB_PERF_EN
    output logic [DBITS-1:0]     perf_pipe_grants,
    output logic [DBITS-1:0]     perf_mdu_grants,
    output logic [DBITS-1:0]     perf_stall_cycles,
`endif
    output arb_state_t           dbg_state,
    output logic                 mdu_pending
);

    localparam int ENTRY_W  = REGNOBITS + DBITS;
    localparam int BUNDLE_W = wb_bundle_w(REGNOBITS, DBITS);
    localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t           state;
    logic [CNT_W-1:0]     starve_cnt;
    logic [BUNDLE_W-1:0]  wb_bundle;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_head;
    logic [REGNOBITS-1:0] head_regno;
    logic [DBITS-1:0]     head_val;
    logic                 mdu_push;

    logic                 pipe_req;
    logic                 mdu_req;
    logic                 grant_pipe;
    logic                 grant_mdu;

    wb_mdu_fifo #(
        .DEPTH (MDU_FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mdu_push),
        .push_data ({mdu_wregno, mdu_regval}),
        .pop       (grant_mdu),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign head_regno  = fifo_head[ENTRY_W-1 -: REGNOBITS];
    assign head_val    = fifo_head[DBITS-1:0];
    assign mdu_ready   = reset && !fifo_full;
    assign mdu_push    = mdu_valid && mdu_ready;
    assign mdu_pending = !fifo_empty;
    assign dbg_state   = state;

    // Request qualification and grant: pipeline first unless draining.
    always_comb begin
        pipe_req   = pipe_wr_valid && (pipe_wregno != '0);
        mdu_req    = !fifo_empty;
        grant_pipe = 1'b0;
        grant_mdu  = 1'b0;
        pipe_stall = 1'b0;
        if (state == S_DRAIN) begin
            grant_mdu  = mdu_req;
            pipe_stall = reset && pipe_req;
        end else begin
            grant_pipe = pipe_req;
            grant_mdu  = !pipe_req && mdu_req;
        end
    end

    // Arbiter FSM with saturating starvation counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_PIPE;
            starve_cnt <= '0;
        end else begin
            case (state)
                S_PIPE: begin
                    if (mdu_req && !grant_mdu) begin
                        if (starve_cnt == CNT_LAST) begin
                            state <= S_DRAIN;
                        end else begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    state      <= S_PIPE;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= S_PIPE;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    // Registered write bundle; address/data hold when nothing is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_bundle <= '0;
        end else if (grant_pipe) begin
            wb_bundle <= {1'b1, pipe_wregno, pipe_regval};
        end else if (grant_mdu && (head_regno != '0)) begin
            wb_bundle <= {1'b1, head_regno, head_val};
        end else begin
            wb_bundle[BUNDLE_W-1] <= 1'b0;
        end
    end

    assign wr_reg_out = wb_bundle[BUNDLE_W-1];
    assign wregno_out = wb_bundle[DBITS +: REGNOBITS];
    assign regval_out = wb_bundle[DBITS-1:0];

`ifdef WB_ARB_PERF_EN
    // Free-running performance counters, wrapping at 2^DBITS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_pipe_grants  <= '0;
            perf_mdu_grants   <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (grant_pipe) perf_pipe_grants  <= perf_pipe_grants + DBITS'(1);
            if (grant_mdu)  perf_mdu_grants   <= perf_mdu_grants + DBITS'(1);
            if (pipe_stall) perf_stall_cycles <= perf_stall_cycles + DBITS'(1);
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter: directed steps followed by a random phase,
// each cycle checked against a queue-based reference model of the port rules.
module tb_wb_write_arbiter;
    import wb_write_arbiter_pkg::*;

    localparam int DBITS          = 32;
    localparam int REGNOBITS      = 5;
    localparam int MDU_FIFO_DEPTH = 2;
    localparam int STARVE_LIMIT   = 4;
    localparam int W              = REGNOBITS + DBITS;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 pipe_wr_valid = 1'b0;
    logic [REGNOBITS-1:0] pipe_wregno = '0;
    logic [DBITS-1:0]     pipe_regval = '0;
    logic                 pipe_stall;
    logic                 mdu_valid = 1'b0;
    logic                 mdu_ready;
    logic [REGNOBITS-1:0] mdu_wregno = '0;
    logic [DBITS-1:0]     mdu_regval = '0;
    logic                 wr_reg_out;
    logic [REGNOBITS-1:0] wregno_out;
    logic [DBITS-1:0]     regval_out;
    arb_state_t           dbg_state;
    logic                 mdu_pending;
`ifdef WB_ARB_PERF_EN
    logic [DBITS-1:0]     perf_pipe_grants;
    logic [DBITS-1:0]     perf_mdu_grants;
    logic [DBITS-1:0]     perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    wb_write_arbiter #(
        .DBITS          (DBITS),
        .REGNOBITS      (REGNOBITS),
        .MDU_FIFO_DEPTH (MDU_FIFO_DEPTH),
        .STARVE_LIMIT   (STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_wr_valid (pipe_wr_valid),
        .pipe_wregno   (pipe_wregno),
        .pipe_regval   (pipe_regval),
        .pipe_stall    (pipe_stall),
        .mdu_valid     (mdu_valid),
        .mdu_ready     (mdu_ready),
        .mdu_wregno    (mdu_wregno),
        .mdu_regval    (mdu_regval),
        .wr_reg_out    (wr_reg_out),
        .wregno_out    (wregno_out),
        .regval_out    (regval_out),
`ifdef WB_ARB_PERF_EN
        .perf_pipe_grants  (perf_pipe_grants),
        .perf_mdu_grants   (perf_mdu_grants),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .dbg_state     (dbg_state),
        .mdu_pending   (mdu_pending)
    );

    // ---------------- scoreboard / reference model ----------------
    int cmp_cnt  = 0;
    int fail_cnt = 0;

    logic [W-1:0]         exp_q[$];     // buffered MDU results, oldest first
    int                   lose_streak = 0;
    bit                   drain_due   = 1'b0;
    bit                   exp_wr      = 1'b0;
    logic [REGNOBITS-1:0] exp_regno   = '0;
    logic [DBITS-1:0]     exp_val     = '0;
    bit                   last_stall  = 1'b0;
    bit                   last_push   = 1'b0;
    bit                   obs_stall   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        cmp_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        lose_streak = 0;
        drain_due   = 1'b0;
        exp_wr      = 1'b0;
        exp_regno   = '0;
        exp_val     = '0;
        last_stall  = 1'b0;
        last_push   = 1'b0;
    endtask

    // One clock cycle: inputs are already driven; check, advance model, step clock.
    task automatic cycle();
        bit p_req, m_req, p_win, m_win, stall, rdy;
        logic [W-1:0] ent;
        #1;
        p_req = pipe_wr_valid && (pipe_wregno != 0);
        m_req = (exp_q.size() != 0);
        rdy   = (exp_q.size() < MDU_FIFO_DEPTH);
        if (drain_due) begin
            m_win = m_req;
            p_win = 1'b0;
            stall = p_req;
        end else begin
            p_win = p_req;
            m_win = !p_req && m_req;
            stall = 1'b0;
        end
        chk("pipe_stall", pipe_stall, stall);
        chk("mdu_ready", mdu_ready, rdy);
        chk("mdu_pending", mdu_pending, m_req);
        chk("wr_reg_out", wr_reg_out, exp_wr);
        chk("dbg_state", dbg_state, drain_due ? 1 : 0);
        if (exp_wr) begin
            chk("wregno_out", wregno_out, exp_regno);
            chk("regval_out", regval_out, exp_val);
        end
        obs_stall  = pipe_stall;
        last_stall = stall;
        last_push  = mdu_valid && rdy;
        // write port next cycle
        if (p_win) begin
            exp_wr    = 1'b1;
            exp_regno = pipe_wregno;
            exp_val   = pipe_regval;
        end else if (m_win) begin
            ent    = exp_q.pop_front();
            exp_wr = (ent[W-1 -: REGNOBITS] != 0);
            if (exp_wr) begin
                exp_regno = ent[W-1 -: REGNOBITS];
                exp_val   = ent[DBITS-1:0];
            end
        end else begin
            exp_wr = 1'b0;
        end
        // starvation: STARVE_LIMIT consecutive losses force the next cycle
        if (drain_due) begin
            drain_due   = 1'b0;
            lose_streak = 0;
        end else if (m_req && !m_win) begin
            lose_streak++;
            if (lose_streak >= STARVE_LIMIT) drain_due = 1'b1;
        end else begin
            lose_streak = 0;
        end
        if (last_push) exp_q.push_back({mdu_wregno, mdu_regval});
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pipe_drive(input bit v, input logic [REGNOBITS-1:0] r, input logic [DBITS-1:0] d);
        if (!last_stall) begin
            pipe_wr_valid = v;
            pipe_wregno   = r;
            pipe_regval   = d;
        end
    endtask

    task automatic mdu_drive(input bit v, input logic [REGNOBITS-1:0] r, input logic [DBITS-1:0] d);
        mdu_valid  = v;
        mdu_wregno = r;
        mdu_regval = d;
    endtask

    // Assert reset asynchronously (mid-cycle) and check reset values over a cycle.
    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_pending"}, mdu_pending, 0);
            chk({tag, "_ready"}, mdu_ready, 0);
            chk({tag, "_stall"}, pipe_stall, 0);
            chk({tag, "_wr"}, wr_reg_out, 0);
            chk({tag, "_wregno"}, wregno_out, 0);
            chk({tag, "_regval"}, regval_out, 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    logic [REGNOBITS-1:0] m_r[3] = '{5'd20, 5'd21, 5'd22};
    logic [DBITS-1:0]     m_d[3] = '{32'hA001, 32'hA002, 32'hA003};

    initial begin
        int k;
        int stalls;
        int mdu_seen;

        // Power-on reset
        reset_pulse("por");

        // Reset mid-push with two entries buffered
        pipe_drive(1, 5'd1, 32'h11);
        mdu_drive(1, 5'd9, 32'h900);
        cycle();
        pipe_drive(1, 5'd2, 32'h22);
        mdu_drive(1, 5'd10, 32'h1000);
        cycle();
        pipe_drive(1, 5'd3, 32'h33);
        mdu_drive(1, 5'd11, 32'h1100);
        cycle();                          // buffer full, mdu_ready low
        reset_pulse("midrst");            // handshake in flight discarded
        pipe_drive(0, 0, 0);
        mdu_drive(0, 0, 0);
        cycle();
        cycle();
        chk("post_rst_no_write", wr_reg_out, 0);

        // Pipeline write x5 = 0x1234, MDU idle
        pipe_drive(1, 5'd5, 32'h1234);
        cycle();
        pipe_drive(0, 0, 0);
        cycle();
        cycle();

        // MDU result x7 = 0xBEEF with pipe idle
        mdu_drive(1, 5'd7, 32'hBEEF);
        cycle();
        mdu_drive(0, 0, 0);
        cycle();
        cycle();
        cycle();

        // Starvation: continuous pipe writes, one buffered MDU result
        stalls = 0;
        mdu_drive(1, 5'd12, 32'hC0DE);
        for (int i = 0; i < 9; i++) begin
            pipe_drive(1, REGNOBITS'(i % 4 + 1), 32'h5000 + i);
            cycle();
            mdu_drive(0, 0, 0);
            stalls += obs_stall;
        end
        chk("starve_stall_cycles", stalls, 1);
        pipe_drive(0, 0, 0);
        cycle();
        cycle();

        // Three MDU results against a busy pipe; third held off while full
        k = 0;
        mdu_seen = 0;
        for (int i = 0; i < 20; i++) begin
            pipe_drive(i < 12, REGNOBITS'(i % 4 + 1), 32'h6000 + i);
            if (k < 3) mdu_drive(1, m_r[k], m_d[k]);
            else mdu_drive(0, 0, 0);
            cycle();
            if (last_push) k++;
            if (wr_reg_out && wregno_out >= 20) mdu_seen++;
        end
        chk("mdu_all_out", mdu_seen, 3);

        // x0 writes from both sources
        pipe_drive(1, 5'd0, 32'hFFFF);
        mdu_drive(1, 5'd0, 32'hDEAD);
        cycle();
        mdu_drive(0, 0, 0);
        cycle();
        cycle();
        pipe_drive(0, 0, 0);
        cycle();
        chk("x0_pending_clear", mdu_pending, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            pipe_drive($urandom_range(0, 9) < 7, REGNOBITS'($urandom_range(0, 7)), $urandom);
            if (!(mdu_valid && !last_push)) begin
                mdu_drive($urandom_range(0, 9) < 4, REGNOBITS'($urandom_range(0, 31)), $urandom);
            end
            cycle();
        end
        pipe_drive(0, 0, 0);
        mdu_drive(0, 0, 0);
        for (int i = 0; i < 6; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
